q_operand_loader: RTL

Upstream feeder for `Q_calculator`. It accepts a stream of signed operand words, one per beat, using valid/ready handshaking with a last-beat marker. It assembles each 4-beat frame into `a`, `b`, `c`, `d` and issues one `valid_in` pulse. It then holds the operands and blocks the stream until the calculator answers with `valid_out`, which serialises frames into the non-pipelined calculator.

---
 rtl/q_calc_pkg.sv | 13 +
 rtl/q_loader_timer.sv | 26 ++
 rtl/q_operand_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/q_calc_pkg.sv
// Shared types for the Q_calculator operand loader: FSM states, slot index, default width.
package q_calc_pkg;
  localparam int Q_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DROP    = 2'd3
  } q_loader_state_e;

  typedef logic [1:0] q_slot_t;
endpackage

// File: rtl/q_loader_timer.sv
// WAIT-cycle counter: cleared on clr_i, counts while en_i, expired_o on the last allowed cycle.
module q_loader_timer #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q == CYCLES-1 means this is the CYCLES-th WAIT cycle
  assign expired_o = en_i && (cnt_q == 16'(CYCLES - 1));
endmodule

// File: rtl/q_operand_loader.sv
// Assembles 4-beat operand frames for Q_calculator, issues one valid_in and blocks until valid_out.
// Optional WAIT timeout under `Q_LOADER_TIMEOUT_EN; ready-low stalls the stream during ISSUE/WAIT.
module q_operand_loader
  import q_calc_pkg::*;
#(
  parameter int WIDTH          = Q_DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] calc_a,
  output logic signed [WIDTH-1:0] calc_b,
  output logic signed [WIDTH-1:0] calc_c,
  output logic signed [WIDTH-1:0] calc_d,
  output logic                    calc_valid_in,
  input  logic                    calc_valid_out,
  output logic                    frame_err,
  output logic                    timeout,
  output logic [15:0]             frame_cnt
);
  q_loader_state_e         state_q, state_d;
  q_slot_t                 idx_q, idx_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                    vin_q, vin_d, ferr_q, ferr_d, tout_q, tout_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    accept, tmr_expired;

  assign s_ready = !rst && ((state_q == ST_COLLECT) || (state_q == ST_DROP));
  assign accept  = s_valid && s_ready;

`ifdef Q_LOADER_TIMEOUT_EN
  q_loader_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     (state_q == ST_WAIT),
    .expired_o(tmr_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmr_expired        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      vin_q   <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      vin_q   <= vin_d;
      ferr_q  <= ferr_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (accept && idx_q == 2'd3) state_d = s_last ? ST_ISSUE : ST_DROP;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (calc_valid_out || tmr_expired) state_d = ST_COLLECT;
      ST_DROP:    if (accept && s_last) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    vin_d  = 1'b0;
    ferr_d = 1'b0;
    tout_d = 1'b0;
    cnt_d  = cnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (idx_q != 2'd3) begin
            if (s_last) begin
              ferr_d = 1'b1;
              idx_d  = '0;
            end else begin
              case (idx_q)
                2'd0:    a_d = s_data;
                2'd1:    b_d = s_data;
                default: c_d = s_data;
              endcase
              idx_d = idx_q + 2'd1;
            end
          end else begin
            // Overlong frame stores nothing; DROP swallows the rest
            if (s_last) begin
              d_d   = s_data;
              vin_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            idx_d = '0;
          end
        end
      end
      ST_ISSUE: cnt_d = cnt_q + 16'd1;
      ST_WAIT:  if (!calc_valid_out && tmr_expired) tout_d = 1'b1;
      default:  ;
    endcase
  end

  assign calc_a        = a_q;
  assign calc_b        = b_q;
  assign calc_c        = c_q;
  assign calc_d        = d_q;
  assign calc_valid_in = vin_q;
  assign frame_err     = ferr_q;
  assign timeout       = tout_q;
  assign frame_cnt     = cnt_q;
endmodule
